// File: rtl/retire_map_unit_pkg.sv
// Shared types and sizing for the retirement map and its free list.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package retire_map_unit_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PW            = $clog2(NUM_PHYS_REGS);
    localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_AW         = $clog2(FL_DEPTH);
    // Free-list pointers and the count carry one extra bit (wrap bit).
    localparam int CNT_W         = FL_AW + 1;

    typedef logic [5:0]       phys_reg_t;
    typedef logic [4:0]       arch_reg_t;
    typedef logic [CNT_W-1:0] fl_ptr_t;

endpackage

// File: rtl/retire_map_unit_if.sv
// Retire/rename-facing bundle: ROB commit, rename allocation, flush, map export.
// Latency: n/a (wires only).
// Backpressure: none; alloc_valid is the only availability indication.
interface retire_map_unit_if;
    import retire_map_unit_pkg::*;

    logic                        commit_valid;
    arch_reg_t                   commit_rd;
    phys_reg_t                   commit_pd;
    logic                        commit_we;
    logic                        alloc_req;
    phys_reg_t                   alloc_pd;
    logic                        alloc_valid;
    logic                        flush;
    logic [NUM_ARCH_REGS*PW-1:0] rrf_map;
    logic [CNT_W-1:0]            free_count;

    // Driven by the ROB / rename side.
    modport master (
        output commit_valid, commit_rd, commit_pd, commit_we, alloc_req, flush,
        input  alloc_pd, alloc_valid, rrf_map, free_count
    );

    // Driven by the retire map unit.
    modport slave (
        input  commit_valid, commit_rd, commit_pd, commit_we, alloc_req, flush,
        output alloc_pd, alloc_valid, rrf_map, free_count
    );

endinterface

// File: rtl/retire_map_unit_free_list.sv
// Circular free list of physical tags with wrap-bit pointers, reset preload and one-cycle flush restore.
// Latency: pop_dat/pop_vld combinational from head; push/pop take effect at the next edge. Optional FL_BYPASS_EN forwards a same-cycle push while empty.
// Backpressure: pop ignored while empty (unless bypassed) or during flush; push while full is dropped.
module retire_map_unit_free_list
    import retire_map_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  phys_reg_t        push_dat,
    input  logic             pop_req,
    input  logic             flush,
    output phys_reg_t        pop_dat,
    output logic             pop_vld,
    output logic [CNT_W-1:0] count
);

    phys_reg_t fl [FL_DEPTH];
    fl_ptr_t   head;
    fl_ptr_t   tail;
    fl_ptr_t   head_nxt;
    fl_ptr_t   tail_nxt;
    logic      empty;
    logic      full;
    logic      push_ok;
    logic      pop_ok;
    logic      byp;

    assign empty   = (head == tail);
    assign full    = (head[FL_AW-1:0] == tail[FL_AW-1:0]) && (head[FL_AW] != tail[FL_AW]);
    assign push_ok = push_vld && !full;

`ifdef FL_BYPASS_EN
    // An empty list can hand out the tag being freed this very cycle.
    assign byp = empty && push_ok;
`else
    assign byp = 1'b0;
`endif

    assign pop_vld = !empty || byp;
    assign pop_dat = byp ? push_dat : fl[head[FL_AW-1:0]];
    assign pop_ok  = pop_req && pop_vld && !flush;
    assign count   = tail - head;

    // Next pointers; flush places head one full lap behind the post-push tail,
    // which reclaims every speculatively handed-out tag still sitting in its slot.
    always_comb begin
        tail_nxt = tail + CNT_W'(push_ok);
        head_nxt = head + CNT_W'(pop_ok);
        if (flush) begin
            head_nxt = {~tail_nxt[FL_AW], tail_nxt[FL_AW-1:0]};
        end
    end

    // Storage and pointer update; reset preloads tags NUM_ARCH_REGS.. in order, list full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= phys_reg_t'(NUM_ARCH_REGS + i);
            end
            head <= '0;
            tail <= {1'b1, {FL_AW{1'b0}}};
        end else begin
            if (push_ok) begin
                fl[tail[FL_AW-1:0]] <= push_dat;
            end
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

endmodule

// File: rtl/retire_map_unit.sv
// Retirement register file (committed arch->phys map) plus the free list it feeds; FL_BYPASS_EN enables free-list bypass.
// Latency: map update and freed-tag push land one cycle after commit; allocation tag is combinational.
// Backpressure: none toward the ROB; rename sees alloc_valid low when no tag is free.
module retire_map_unit
    import retire_map_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    retire_map_unit_if.slave bus
);

    phys_reg_t                   rrf [NUM_ARCH_REGS];
    logic                        commit_eff;
    phys_reg_t                   old_pd;
    logic [NUM_ARCH_REGS*PW-1:0] rrf_map;
    phys_reg_t                   alloc_pd;
    logic                        alloc_valid;
    logic [CNT_W-1:0]            free_count;

    // x0 is never renamed, so commits to it neither change the map nor free a tag.
    assign commit_eff = bus.commit_valid && bus.commit_we && (bus.commit_rd != '0);
    assign old_pd     = rrf[bus.commit_rd];

    // Committed map; a flush needs no action here since retirement is never speculative.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rrf[i] <= phys_reg_t'(i);
            end
        end else if (commit_eff) begin
            rrf[bus.commit_rd] <= bus.commit_pd;
        end
    end

    // Flatten the map for the rename-side rebuild after a flush.
    always_comb begin
        rrf_map = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            rrf_map[i*PW +: PW] = rrf[i];
        end
    end

    retire_map_unit_free_list u_free_list (
        .clk      (clk),
        .rst      (rst),
        .push_vld (commit_eff),
        .push_dat (old_pd),
        .pop_req  (bus.alloc_req),
        .flush    (bus.flush),
        .pop_dat  (alloc_pd),
        .pop_vld  (alloc_valid),
        .count    (free_count)
    );

    assign bus.rrf_map     = rrf_map;
    assign bus.alloc_pd    = alloc_pd;
    assign bus.alloc_valid = alloc_valid;
    assign bus.free_count  = free_count;

endmodule

// File: tb/tb_retire_map_unit.sv
// Bench for retire_map_unit: free-list scoreboard queue plus committed-map model.
// Latency: checks allocation outputs mid-cycle and registered state on the falling edge.
// Backpressure: commits are withheld while the model list is full.
module tb_retire_map_unit;
    import retire_map_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    retire_map_unit_if bus();
    retire_map_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    phys_reg_t fl_q[$];   // expected free tags, head first
    phys_reg_t hist[$];   // every tag handed out, in order
    phys_reg_t m_rrf [NUM_ARCH_REGS];

    task automatic model_reset();
        fl_q.delete();
        hist.delete();
        for (int i = 0; i < FL_DEPTH; i++) fl_q.push_back(phys_reg_t'(NUM_ARCH_REGS + i));
        for (int i = 0; i < NUM_ARCH_REGS; i++) m_rrf[i] = phys_reg_t'(i);
    endtask

    function automatic logic [NUM_ARCH_REGS*PW-1:0] model_map();
        logic [NUM_ARCH_REGS*PW-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) m[i*PW +: PW] = m_rrf[i];
        return m;
    endfunction

    task automatic idle();
        bus.commit_valid = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_pd    = '0;
        bus.commit_we    = 1'b0;
        bus.alloc_req    = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus, entered and left on a falling edge. Expected tags are
    // pushed to fl_q when a commit is driven and popped when an allocation is taken.
    task automatic step(input logic a, input logic cv, input logic we, input arch_reg_t rd,
                        input phys_reg_t pd, input logic fl,
                        output logic got_vld, output phys_reg_t got_pd,
                        output logic exp_vld, output phys_reg_t exp_pd);
        logic      eff, push, byp, pop;
        phys_reg_t old;
        int        n;
        bus.alloc_req    = a;
        bus.commit_valid = cv;
        bus.commit_we    = we;
        bus.commit_rd    = rd;
        bus.commit_pd    = pd;
        bus.flush        = fl;
        eff  = cv && we && (rd != 0);
        push = eff && (fl_q.size() < FL_DEPTH);
        old  = m_rrf[rd];
`ifdef FL_BYPASS_EN
        byp  = (fl_q.size() == 0) && push;
`else
        byp  = 1'b0;
`endif
        exp_vld = (fl_q.size() != 0) || byp;
        exp_pd  = (fl_q.size() != 0) ? fl_q[0] : old;
        #1;
        got_vld = bus.alloc_valid;
        got_pd  = bus.alloc_pd;
        @(posedge clk);
        pop = a && exp_vld && !fl;
        if (pop && fl_q.size() != 0) begin
            hist.push_back(fl_q.pop_front());
            if (push) fl_q.push_back(old);
        end else if (pop) begin
            hist.push_back(old);
        end else if (push) begin
            fl_q.push_back(old);
        end
        if (eff) m_rrf[rd] = pd;
        if (fl) begin
            n = FL_DEPTH - fl_q.size();
            for (int k = 0; k < n && k < hist.size(); k++) fl_q.push_front(hist[hist.size()-1-k]);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.alloc_pd !== 6'd32) begin errors++; $display("FAIL reset_alloc_pd got %0d want 32", bus.alloc_pd); end
        checks++; if (bus.alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_alloc_valid got %b want 1", bus.alloc_valid); end
        checks++; if (bus.free_count !== 6'd32) begin errors++; $display("FAIL reset_free_count got %0d want 32", bus.free_count); end
        checks++; if (bus.rrf_map[5*PW +: PW] !== 6'd5) begin errors++; $display("FAIL reset_rrf5 got %0d want 5", bus.rrf_map[5*PW +: PW]); end
        checks++; if (bus.rrf_map !== model_map()) begin errors++; $display("FAIL reset_map got %h want %h", bus.rrf_map, model_map()); end
    endtask

    task automatic test_alloc_commit();
        logic gv, ev; phys_reg_t gp, ep;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
            checks++; if (gv !== ev || gp !== ep) begin errors++; $display("FAIL alloc%0d got %b/%0d want %b/%0d", i, gv, gp, ev, ep); end
        end
        step(0, 1, 1, 5, 32, 0, gv, gp, ev, ep);
        checks++; if (bus.rrf_map[5*PW +: PW] !== 6'd32) begin errors++; $display("FAIL commit_rrf5 got %0d want 32", bus.rrf_map[5*PW +: PW]); end
        checks++; if (bus.alloc_pd !== 6'd35) begin errors++; $display("FAIL commit_alloc_pd got %0d want 35", bus.alloc_pd); end
        checks++; if (bus.free_count !== 6'd30) begin errors++; $display("FAIL commit_free_count got %0d want 30", bus.free_count); end
    endtask

    task automatic test_drain_and_bypass();
        logic gv, ev; phys_reg_t gp, ep;
        do_reset();
        for (int i = 0; i < FL_DEPTH; i++) begin
            step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
            checks++; if (gv !== ev || gp !== ep) begin errors++; $display("FAIL drain%0d got %b/%0d want %b/%0d", i, gv, gp, ev, ep); end
        end
        checks++; if (bus.alloc_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", bus.alloc_valid); end
        checks++; if (bus.free_count !== 6'd0) begin errors++; $display("FAIL empty_count got %0d want 0", bus.free_count); end
        step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
        checks++; if (bus.free_count !== 6'd0 || bus.alloc_valid !== 1'b0) begin errors++; $display("FAIL empty_alloc count %0d valid %b want 0 0", bus.free_count, bus.alloc_valid); end
        // Free tag 4 without allocating; head must not have moved, so tag 4 is next.
        step(0, 1, 1, 4, 40, 0, gv, gp, ev, ep);
        checks++; if (bus.alloc_valid !== 1'b1 || bus.alloc_pd !== 6'd4) begin errors++; $display("FAIL refill got %b/%0d want 1/4", bus.alloc_valid, bus.alloc_pd); end
        step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
        // Empty again; commit rd=3 (maps to 3) together with an allocation.
        step(1, 1, 1, 3, 41, 0, gv, gp, ev, ep);
`ifdef FL_BYPASS_EN
        checks++; if (gv !== 1'b1 || gp !== 6'd3) begin errors++; $display("FAIL bypass_same_cycle got %b/%0d want 1/3", gv, gp); end
        checks++; if (bus.free_count !== 6'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", bus.free_count); end
`else
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle got %b want 0", gv); end
        checks++; if (bus.free_count !== 6'd1 || bus.alloc_pd !== 6'd3) begin errors++; $display("FAIL nobypass_next count %0d pd %0d want 1 3", bus.free_count, bus.alloc_pd); end
`endif
        checks++; if (bus.rrf_map !== model_map()) begin errors++; $display("FAIL bypass_map got %h want %h", bus.rrf_map, model_map()); end
    endtask

    task automatic test_flush();
        logic gv, ev; phys_reg_t gp, ep;
        bit saw7;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
        step(1, 1, 1, 7, 33, 1, gv, gp, ev, ep);
        checks++; if (bus.rrf_map[7*PW +: PW] !== 6'd33) begin errors++; $display("FAIL flush_rrf7 got %0d want 33", bus.rrf_map[7*PW +: PW]); end
        checks++; if (bus.free_count !== 6'd32) begin errors++; $display("FAIL flush_count got %0d want 32", bus.free_count); end
        saw7 = 0;
        for (int i = 0; i < FL_DEPTH; i++) begin
            step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
            if (gp == 6'd7) saw7 = 1;
            checks++; if (gv !== ev || gp !== ep) begin errors++; $display("FAIL flush_drain%0d got %b/%0d want %b/%0d", i, gv, gp, ev, ep); end
        end
        checks++; if (saw7 !== 1'b1) begin errors++; $display("FAIL flush_tag7 seen %b want 1", saw7); end
    endtask

    task automatic test_x0();
        logic gv, ev; phys_reg_t gp, ep;
        do_reset();
        step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
        step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
        step(0, 1, 1, 0, 40, 0, gv, gp, ev, ep);
        checks++; if (bus.free_count !== 6'd30) begin errors++; $display("FAIL x0_count got %0d want 30", bus.free_count); end
        checks++; if (bus.rrf_map[0 +: PW] !== 6'd0 || bus.rrf_map !== model_map()) begin errors++; $display("FAIL x0_map got %h want %h", bus.rrf_map, model_map()); end
        step(0, 1, 0, 9, 41, 0, gv, gp, ev, ep);
        checks++; if (bus.rrf_map[9*PW +: PW] !== 6'd9 || bus.free_count !== 6'd30) begin errors++; $display("FAIL we0 rrf9 %0d count %0d want 9 30", bus.rrf_map[9*PW +: PW], bus.free_count); end
        checks++; if (bus.alloc_pd !== 6'd34) begin errors++; $display("FAIL x0_alloc_pd got %0d want 34", bus.alloc_pd); end
    endtask

    task automatic test_back_to_back();
        logic gv, ev; phys_reg_t gp, ep;
        logic a, cv, we, fl; arch_reg_t rd; phys_reg_t pd;
        step(1, 1, 1, 10, 50, 0, gv, gp, ev, ep);
        checks++; if (bus.free_count !== 6'd30) begin errors++; $display("FAIL b2b_count got %0d want 30", bus.free_count); end
        for (int i = 0; i < 400; i++) begin
            a  = 1'($urandom_range(0, 1));
            cv = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 7) != 0);
            rd = arch_reg_t'($urandom_range(0, 31));
            pd = phys_reg_t'($urandom_range(0, 63));
            fl = ($urandom_range(0, 24) == 0);
            if (fl_q.size() >= FL_DEPTH) cv = 1'b0;
            step(a, cv, we, rd, pd, fl, gv, gp, ev, ep);
            checks++; if (gv !== ev || (ev && gp !== ep)) begin errors++; $display("FAIL rnd%0d_alloc got %b/%0d want %b/%0d", i, gv, gp, ev, ep); end
            checks++; if (bus.free_count !== CNT_W'(fl_q.size())) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", i, bus.free_count, fl_q.size()); end
            checks++; if (bus.rrf_map !== model_map()) begin errors++; $display("FAIL rnd%0d_map got %h want %h", i, bus.rrf_map, model_map()); end
        end
    endtask

    task automatic test_midop_reset();
        logic gv, ev; phys_reg_t gp, ep;
        for (int i = 0; i < 5; i++) step(1, 1, 1, arch_reg_t'(i + 1), phys_reg_t'(i + 40), 0, gv, gp, ev, ep);
        bus.commit_valid = 1'b1; bus.commit_we = 1'b1; bus.commit_rd = 5'd6; bus.commit_pd = 6'd60;
        bus.flush = 1'b1; bus.alloc_req = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.free_count !== 6'd32 || bus.alloc_pd !== 6'd32 || bus.alloc_valid !== 1'b1) begin errors++; $display("FAIL midreset count %0d pd %0d valid %b want 32 32 1", bus.free_count, bus.alloc_pd, bus.alloc_valid); end
        checks++; if (bus.rrf_map !== model_map()) begin errors++; $display("FAIL midreset_map got %h want %h", bus.rrf_map, model_map()); end
        @(negedge clk);
        idle();
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 0, gv, gp, ev, ep);
        checks++; if (gv !== 1'b1 || gp !== 6'd32) begin errors++; $display("FAIL post_reset_alloc got %b/%0d want 1/32", gv, gp); end
    endtask

    initial begin
        test_reset();
        test_alloc_commit();
        test_drain_and_bypass();
        test_flush();
        test_x0();
        test_back_to_back();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
